mem_rr_arbiter: RTL and testbench

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_rr_arbiter_if.sv | 29 ++
 rtl/mem_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if -- one picorv32-style native memory port.
//
// The requester drives valid/instr/addr/wdata/wstrb and receives ready/rdata.
// wstrb == 0 marks a read. ready is a one-cycle completion strobe; rdata is
// only meaningful in the ready cycle.
//
// Modports:
//   master : the side issuing requests (a CPU, or the arbiter towards memory)
//   slave  : the side serving requests (memory, or the arbiter towards a CPU)

interface mem_rr_arbiter_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter -- two-master round-robin arbiter onto one shared memory port.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   resetn       synchronous active-low reset
//   m0, m1       requester ports (slave modport of mem_rr_arbiter_if)
//   s            shared-memory port (master modport of mem_rr_arbiter_if)
//   grant        one-hot owner: 01 master 0, 10 master 1, 00 none
//   timeout_err  one-cycle pulse when a transaction is force-completed
//
// A request seen while idle is granted on the next edge; the owner's request
// is then passed straight through to memory until it completes or is dropped.
// Ties go to the master that did not complete last. There is always at least
// one idle cycle between transactions.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to force-complete a transaction
// after TIMEOUT_CYCLES busy cycles without s.ready, returning 32'hDEADBEEF.
// Without the macro there is no counter, timeout_err is tied low and a grant
// waits for s.ready indefinitely.

module mem_rr_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              resetn,
   mem_rr_arbiter_if.slave   m0,
   mem_rr_arbiter_if.slave   m1,
   mem_rr_arbiter_if.master  s,
   output logic [1:0]        grant,
   output logic              timeout_err
);

   // Encoding chosen so that the state register doubles as the grant vector.
   localparam logic [1:0]  IDLE  = 2'b00;
   localparam logic [1:0]  BUSY0 = 2'b01;
   localparam logic [1:0]  BUSY1 = 2'b10;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("mem_rr_arbiter: TIMEOUT_CYCLES must be in 2..65535");
   end

   logic [1:0]  state_q, state_d;
   logic        lg_q, lg_d;       // master that completed most recently
   logic        busy;
   logic        sel;              // owner index while busy
   logic        req_valid;
   logic        req_instr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        done;
   logic        forced;

   assign busy  = (state_q != IDLE);
   assign sel   = (state_q == BUSY1);
   assign grant = state_q;

   // Owner's request, selected before gating with busy.
   always_comb begin
      req_valid = sel ? m1.valid : m0.valid;
      req_instr = sel ? m1.instr : m0.instr;
      req_addr  = sel ? m1.addr  : m0.addr;
      req_wdata = sel ? m1.wdata : m0.wdata;
      req_wstrb = sel ? m1.wstrb : m0.wstrb;
   end

   // Memory side is held at zero while idle.
   always_comb begin
      s.valid = busy & req_valid;
      s.instr = busy & req_instr;
      s.addr  = busy ? req_addr  : 32'd0;
      s.wdata = busy ? req_wdata : 32'd0;
      s.wstrb = busy ? req_wstrb : 4'd0;
   end

   // s.valid is zero while idle, so a stray s.ready there completes nothing.
   assign done = s.valid & s.ready;

`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   // Normal completion has priority: forced only when s.ready is still low.
   assign forced = s.valid & ~s.ready & (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   // Held at zero while idle so every grant starts counting from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!busy) begin
         cnt_d = 16'd0;
      end else if (!s.ready) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign forced = 1'b0;
`endif

   assign timeout_err = forced;

   // Ready only to the owner; rdata is shared except on a forced completion.
   always_comb begin
      m0.ready = (state_q == BUSY0) & (done | forced);
      m1.ready = (state_q == BUSY1) & (done | forced);
      m0.rdata = ((state_q == BUSY0) && forced) ? TIMEOUT_RDATA : s.rdata;
      m1.rdata = ((state_q == BUSY1) && forced) ? TIMEOUT_RDATA : s.rdata;
   end

   always_comb begin
      state_d = state_q;
      lg_d    = lg_q;
      case (state_q)
         IDLE: begin
            if (m0.valid && m1.valid) begin
               state_d = lg_q ? BUSY0 : BUSY1;
            end else if (m0.valid) begin
               state_d = BUSY0;
            end else if (m1.valid) begin
               state_d = BUSY1;
            end
         end
         BUSY0, BUSY1: begin
            if (done || forced) begin
               state_d = IDLE;
               lg_d    = sel;
            end else if (!req_valid) begin
               // Requester withdrew: release without touching fairness state.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         lg_q    <= 1'b1;    // master 0 wins the first tie
      end else begin
         state_q <= state_d;
         lg_q    <= lg_d;
      end
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter -- self-checking bench for mem_rr_arbiter.
//
// A transaction-level model (owner / last-served / busy-cycle count) predicts
// every output each cycle; directed scenarios add literal expectations on the
// completion log. Build with MEM_ARB_TIMEOUT_EN defined to cover the timeout.

module tb_mem_rr_arbiter;

   localparam int unsigned TO     = 8;
   localparam logic [31:0] RD_XOR = 32'hA5A5_0000;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          abort_after;   // 0: hold until ready
   } req_t;

   typedef struct {
      int          m;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic        to;
      logic [1:0]  gnt;
      int          cyc;
      int          issue;
      int          rise;
   } done_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mem_rr_arbiter_if m0_if ();
   mem_rr_arbiter_if m1_if ();
   mem_rr_arbiter_if s_if ();
   logic [1:0] grant;
   logic       timeout_err;

   mem_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .m0          (m0_if),
      .m1          (m1_if),
      .s           (s_if),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   // Master drive state.
   logic        mv [2];
   logic        mi [2];
   logic [31:0] ma [2];
   logic [31:0] mw [2];
   logic [3:0]  ms [2];
   assign m0_if.valid = mv[0];
   assign m0_if.instr = mi[0];
   assign m0_if.addr  = ma[0];
   assign m0_if.wdata = mw[0];
   assign m0_if.wstrb = ms[0];
   assign m1_if.valid = mv[1];
   assign m1_if.instr = mi[1];
   assign m1_if.addr  = ma[1];
   assign m1_if.wdata = mw[1];
   assign m1_if.wstrb = ms[1];

   // Memory responder: fixed latency after s_valid, or free-running LFSR bit.
   int          lat      = 3;
   int          age      = 0;
   int          age_nxt  = 0;
   logic [15:0] lfsr     = 16'hACE1;
   logic [15:0] lfsr_nxt = 16'hACE1;
   bit          mem_rand = 1'b0;
   assign s_if.ready = mem_rand ? lfsr[0] : (s_if.valid && (age == lat));
   assign s_if.rdata = s_if.addr ^ RD_XOR;

   req_t        rq [2][$];
   logic [31:0] ea [2][$];
   bit          got_ready [2];
   int          held [2];
   int          abort_at [2];
   int          issue [2];
   done_t       dlog [$];

   // Model state: owner (-1 none), last master served, busy cycles without ready.
   int   own     = -1;
   int   last    = 1;
   int   cnt     = 0;
   int   cyc     = 0;
   int   rise    = 0;
   logic prev_sv = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got wait bound expired, expected event (cycle %0d)", nm, cyc);
   endtask

   // Per-cycle reference check and model advance.
   always @(negedge clk) begin
      logic [1:0]  e_grant;
      logic        e_sv, e_si, e_to;
      logic [31:0] e_sa, e_sw;
      logic [3:0]  e_ss;
      logic        e_rdy [2];
      logic [31:0] e_rd [2];
      logic        rdy_a [2];
      bit          fin, to;
      done_t       d;

      cyc++;
      e_grant  = 2'b00;
      e_sv     = 1'b0;
      e_si     = 1'b0;
      e_sa     = 32'd0;
      e_sw     = 32'd0;
      e_ss     = 4'd0;
      e_to     = 1'b0;
      e_rdy[0] = 1'b0;
      e_rdy[1] = 1'b0;
      e_rd[0]  = s_if.rdata;
      e_rd[1]  = s_if.rdata;
      fin      = 1'b0;
      to       = 1'b0;
      if (own >= 0) begin
         e_grant = (own == 0) ? 2'b01 : 2'b10;
         e_sv    = mv[own];
         e_si    = mi[own];
         e_sa    = ma[own];
         e_sw    = mw[own];
         e_ss    = ms[own];
         fin     = mv[own] && s_if.ready;
         to      = TO_EN && mv[own] && !s_if.ready && (cnt == int'(TO) - 1);
         if (fin || to) e_rdy[own] = 1'b1;
         if (to) begin
            e_rd[own] = 32'hDEADBEEF;
            e_to      = 1'b1;
         end
      end
      chk("grant",       32'(grant),          32'(e_grant));
      chk("s_valid",     32'(s_if.valid),     32'(e_sv));
      chk("s_instr",     32'(s_if.instr),     32'(e_si));
      chk("s_addr",      s_if.addr,           e_sa);
      chk("s_wdata",     s_if.wdata,          e_sw);
      chk("s_wstrb",     32'(s_if.wstrb),     32'(e_ss));
      chk("m0_ready",    32'(m0_if.ready),    32'(e_rdy[0]));
      chk("m1_ready",    32'(m1_if.ready),    32'(e_rdy[1]));
      chk("m0_rdata",    m0_if.rdata,         e_rd[0]);
      chk("m1_rdata",    m1_if.rdata,         e_rd[1]);
      chk("timeout_err", 32'(timeout_err),    32'(e_to));

      if (s_if.valid && !prev_sv) rise = cyc;
      prev_sv  = s_if.valid;
      rdy_a[0] = m0_if.ready;
      rdy_a[1] = m1_if.ready;
      for (int m = 0; m < 2; m++) begin
         if (rdy_a[m]) begin
            d.m     = m;
            d.instr = s_if.instr;
            d.addr  = s_if.addr;
            d.wdata = s_if.wdata;
            d.wstrb = s_if.wstrb;
            d.rdata = (m == 0) ? m0_if.rdata : m1_if.rdata;
            d.to    = timeout_err;
            d.gnt   = grant;
            d.cyc   = cyc;
            d.issue = issue[m];
            d.rise  = rise;
            dlog.push_back(d);
            got_ready[m] = 1'b1;
         end
      end

      age_nxt  = (s_if.valid && !s_if.ready) ? age + 1 : 0;
      lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (!resetn) begin
         own  = -1;
         last = 1;
         cnt  = 0;
      end else if (own < 0) begin
         if (mv[0] && mv[1]) own = 1 - last;
         else if (mv[0])     own = 0;
         else if (mv[1])     own = 1;
         cnt = 0;
      end else if (fin || to) begin
         last = own;
         own  = -1;
      end else if (!mv[own]) begin
         own = -1;
      end else begin
         cnt++;
      end
   end

   // Master agents and responder state, updated just after each rising edge.
   always begin
      req_t r;
      @(posedge clk);
      #1;
      age  = age_nxt;
      lfsr = lfsr_nxt;
      for (int m = 0; m < 2; m++) begin
         if (mv[m]) begin
            held[m]++;
            if (got_ready[m]) mv[m] = 1'b0;
            else if (abort_at[m] != 0 && held[m] >= abort_at[m]) mv[m] = 1'b0;
         end
         if (!mv[m] && rq[m].size() != 0) begin
            r           = rq[m].pop_front();
            mv[m]       = 1'b1;
            mi[m]       = r.instr;
            ma[m]       = r.addr;
            mw[m]       = r.wdata;
            ms[m]       = r.wstrb;
            abort_at[m] = r.abort_after;
            held[m]     = 0;
            issue[m]    = cyc + 1;
         end
         got_ready[m] = 1'b0;
      end
   end

   task automatic push(input int m, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int ab);
      req_t r;
      r.instr       = instr;
      r.addr        = addr;
      r.wdata       = wdata;
      r.wstrb       = wstrb;
      r.abort_after = ab;
      rq[m].push_back(r);
   endtask

   task automatic wait_done(input string nm, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         #3;
         if (rq[0].size() == 0 && rq[1].size() == 0 && !mv[0] && !mv[1]) break;
      end
      if (i == budget) begin
         bound_fail(nm);
         rq[0].delete();
         rq[1].delete();
         mv[0] = 1'b0;
         mv[1] = 1'b0;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic wait_grant(input string nm, input logic [1:0] g, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (grant == g) break;
      end
      if (i == budget) bound_fail(nm);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rq[0].delete();
      rq[1].delete();
      mv[0]  = 1'b0;
      mv[1]  = 1'b0;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
   endtask

   initial begin
      int n0, n1;
      logic [31:0] ex;
      for (int m = 0; m < 2; m++) begin
         mv[m] = 1'b0; mi[m] = 1'b0; ma[m] = '0; mw[m] = '0; ms[m] = '0;
         got_ready[m] = 1'b0; held[m] = 0; abort_at[m] = 0; issue[m] = 0;
      end
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;

      // Reset state.
      @(negedge clk);
      #1;
      chk("rst_grant",    32'(grant),       32'd0);
      chk("rst_s_valid",  32'(s_if.valid),  32'd0);
      chk("rst_s_addr",   s_if.addr,        32'd0);
      chk("rst_m0_ready", 32'(m0_if.ready), 32'd0);
      chk("rst_to",       32'(timeout_err), 32'd0);

      // Single read, memory answers 3 cycles after s_valid.
      dlog.delete();
      lat = 3;
      push(0, 1'b0, 32'h0000_0100, 32'd0, 4'd0, 0);
      wait_done("t1_wait", 50);
      chk("t1_count", 32'(dlog.size()), 32'd1);
      if (dlog.size() == 1) begin
         chk("t1_master",  32'(dlog[0].m),                   32'd0);
         chk("t1_addr",    dlog[0].addr,                     32'h0000_0100);
         chk("t1_rdata",   dlog[0].rdata,                    32'hA5A5_0100);
         chk("t1_grant",   32'(dlog[0].gnt),                 32'h1);
         chk("t1_rise",    32'(dlog[0].rise - dlog[0].issue), 32'd1);
         chk("t1_latency", 32'(dlog[0].cyc - dlog[0].issue),  32'd4);
      end

      // Tie straight after reset, both held: 0,1,0,1,...
      do_reset();
      dlog.delete();
      lat = 1;
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b0, 32'h200 + 32'(4 * i), 32'd0, 4'd0, 0);
         push(1, 1'b0, 32'h300 + 32'(4 * i), 32'd0, 4'd0, 0);
      end
      wait_done("t2_wait", 200);
      chk("t2_count", 32'(dlog.size()), 32'd8);
      foreach (dlog[k]) begin
         ex = ((k % 2) != 0) ? 32'h300 : 32'h200;
         chk("t2_order", 32'(dlog[k].m), 32'(k % 2));
         chk("t2_addr",  dlog[k].addr,   ex + 32'(4 * (k / 2)));
      end

      // Write pass-through from master 1.
      dlog.delete();
      lat = 2;
      push(1, 1'b0, 32'h1000_0000, 32'h1234_5678, 4'b0011, 0);
      wait_done("t3_wait", 50);
      chk("t3_count", 32'(dlog.size()), 32'd1);
      if (dlog.size() == 1) begin
         chk("t3_master", 32'(dlog[0].m),     32'd1);
         chk("t3_addr",   dlog[0].addr,       32'h1000_0000);
         chk("t3_wdata",  dlog[0].wdata,      32'h1234_5678);
         chk("t3_wstrb",  32'(dlog[0].wstrb), 32'h3);
         chk("t3_rdata",  dlog[0].rdata,      32'hB5A5_0000);
      end

      // Abort leaves fairness untouched: m0 done, m1 aborts, tie goes to m1.
      dlog.delete();
      lat = 1;
      push(0, 1'b1, 32'h400, 32'd0, 4'd0, 0);
      wait_done("t4_wait_a", 50);
      lat = 10;
      push(1, 1'b0, 32'h500, 32'd0, 4'd0, 3);
      wait_done("t4_wait_b", 50);
      chk("t4_abort_no_ready", 32'(dlog.size()), 32'd1);
      lat = 1;
      push(0, 1'b0, 32'h600, 32'd0, 4'd0, 0);
      push(1, 1'b0, 32'h700, 32'd0, 4'd0, 0);
      wait_done("t4_wait_c", 50);
      chk("t4_count", 32'(dlog.size()), 32'd3);
      if (dlog.size() == 3) begin
         chk("t4_instr",     32'(dlog[0].instr), 32'd1);
         chk("t4_tie_first", 32'(dlog[1].m),     32'd1);
         chk("t4_tie_next",  32'(dlog[2].m),     32'd0);
      end

      // Reset while master 1 owns the bus.
      dlog.delete();
      lat = 100;
      push(1, 1'b0, 32'h800, 32'd0, 4'd0, 0);
      wait_grant("t5_grant", 2'b10, 20);
      @(posedge clk);
      #2 resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("t5_s_valid",  32'(s_if.valid),  32'd0);
      chk("t5_grant",    32'(grant),       32'd0);
      chk("t5_m1_ready", 32'(m1_if.ready), 32'd0);
      @(posedge clk);
      #2;
      mv[1]  = 1'b0;
      resetn = 1'b1;
      lat = 1;
      push(0, 1'b0, 32'h900, 32'd0, 4'd0, 0);
      push(1, 1'b0, 32'hA00, 32'd0, 4'd0, 0);
      wait_done("t5_wait", 50);
      chk("t5_count", 32'(dlog.size()), 32'd2);
      if (dlog.size() == 2) chk("t5_tie_first", 32'(dlog[0].m), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory never answers: forced completion on the 8th busy cycle.
      dlog.delete();
      lat = 1000;
      push(0, 1'b0, 32'hB00, 32'd0, 4'd0, 0);
      wait_done("t6_wait", 50);
      chk("t6_count", 32'(dlog.size()), 32'd1);
      if (dlog.size() == 1) begin
         chk("t6_rdata",   dlog[0].rdata,                    32'hDEADBEEF);
         chk("t6_to",      32'(dlog[0].to),                  32'd1);
         chk("t6_latency", 32'(dlog[0].cyc - dlog[0].issue), 32'd8);
      end
`endif

      // Random s_ready, 10k mixed transactions.
      dlog.delete();
      mem_rand = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         for (int m = 0; m < 2; m++) begin
            ex = $urandom;
            push(m, 1'($urandom_range(0, 1)), ex, $urandom, 4'($urandom_range(0, 15)), 0);
            ea[m].push_back(ex);
         end
      end
      wait_done("t7_wait", 60000);
      mem_rand = 1'b0;
      n0 = 0;
      n1 = 0;
      foreach (dlog[k]) begin
         if (dlog[k].m == 0) n0++;
         else n1++;
         if (ea[dlog[k].m].size() != 0) begin
            chk("t7_addr_order", dlog[k].addr, ea[dlog[k].m].pop_front());
         end else begin
            chk("t7_extra_ready", 32'(dlog[k].m), 32'hFFFF_FFFF);
         end
      end
      chk("t7_m0_count", 32'(n0), 32'd5000);
      chk("t7_m1_count", 32'(n1), 32'd5000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running at cycle %0d, expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
